// File: rtl/scan_sel_sequencer_if.sv
// ============================================================================
//  Module   : scan_sel_sequencer_if
//  Purpose  : Control/status bundle between a scan controller and the
//             scan_sel_sequencer select generator.
//  Signals  : start      - begin a frame (controller -> sequencer)
//             abort      - terminate the current frame immediately
//             cont       - repeat mode, sampled at frame end
//             mask[15:0] - slot enable mask, latched at frame start
//             sel[3:0]   - current slot index to the 4-to-16 decoder
//             sel_valid  - decoder enable
//             busy       - a frame is in progress
//             frame_done - one-cycle pulse when a frame completes
//  Modports : master (controller side), slave (sequencer side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_sel_sequencer_if;
    logic        start;
    logic        abort;
    logic        cont;
    logic [15:0] mask;
    logic [3:0]  sel;
    logic        sel_valid;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, abort, cont, mask,
        input  sel, sel_valid, busy, frame_done
    );

    modport slave (
        input  start, abort, cont, mask,
        output sel, sel_valid, busy, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/scan_sel_sequencer.sv
// ============================================================================
//  Module   : scan_sel_sequencer
//  Purpose  : Steps a 4-bit decoder select code through the set bits of a
//             16-slot mask, lowest index first, holding each slot for DWELL
//             cycles. Supports start/done handshake, abort and continuous
//             repeat.
//  Ports    : clk   - system clock, rising edge
//             rst_n - synchronous reset, active-low
//             sif   - scan_sel_sequencer_if.slave (start/abort/cont/mask in,
//                     sel/sel_valid/busy/frame_done out)
//  Params   : DWELL - cycles per selected slot (1..256)
//             SEL_W - select width, fixed at 4 for the 16-output decoder
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_sel_sequencer #(
    parameter int DWELL = 4,
    parameter int SEL_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    scan_sel_sequencer_if.slave    sif
);

    // Timer counts DWELL-1 down to 0, so DWELL=256 still fits in 8 bits.
    localparam int TMR_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TMR_W-1:0] c_TMR_RELOAD = TMR_W'(DWELL - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [15:0]       r_mask;
    logic [TMR_W-1:0]  r_timer;
    logic [SEL_W-1:0]  r_sel;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [SEL_W-1:0]  w_first_idx;
    logic              w_first_found;
    logic [SEL_W-1:0]  w_next_idx;
    logic              w_next_found;

    // Lowest set bit of the live mask (used at every latch point) and the
    // lowest set bit strictly above the current slot in the latched mask.
    // Descending loops leave the lowest qualifying index as the result.
    always_comb begin
        w_first_idx   = '0;
        w_first_found = 1'b0;
        w_next_idx    = '0;
        w_next_found  = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (sif.mask[i]) begin
                w_first_idx   = SEL_W'(i);
                w_first_found = 1'b1;
            end
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_idx   = SEL_W'(i);
                w_next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_timer <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort outranks start; abort alone has no effect here.
                    if (!sif.abort && sif.start) begin
                        if (w_first_found) begin
                            r_mask  <= sif.mask;
                            r_sel   <= w_first_idx;
                            r_timer <= c_TMR_RELOAD;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_SCAN;
                        end else begin
                            // Empty frame: report completion without scanning.
                            r_done <= 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (sif.abort) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_sel   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end else if (w_next_found) begin
                        // Direct slot-to-slot hop keeps the decoder enabled
                        // with no gap cycle.
                        r_sel   <= w_next_idx;
                        r_timer <= c_TMR_RELOAD;
                    end else begin
                        r_done <= 1'b1;
                        if (sif.cont && w_first_found) begin
                            r_mask  <= sif.mask;
                            r_sel   <= w_first_idx;
                            r_timer <= c_TMR_RELOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_sel   <= '0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sif.sel        = r_sel;
    assign sif.sel_valid  = r_valid;
    assign sif.busy       = r_busy;
    assign sif.frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_sel_sequencer.sv
// ============================================================================
//  Module   : tb_scan_sel_sequencer
//  Purpose  : Self-checking bench for scan_sel_sequencer (DWELL=4). Each
//             stimulus cycle pushes the expected {sel,sel_valid,busy,
//             frame_done} for the following clock edge into a scoreboard
//             queue; a monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_scan_sel_sequencer;

    logic clk;
    logic rst_n;

    scan_sel_sequencer_if sif();

    scan_sel_sequencer #(
        .DWELL (4),
        .SEL_W (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed sel=%0d valid=%b busy=%b done=%b, expected sel=%0d valid=%b busy=%b done=%b",
                     tag, obs[6:3], obs[2], obs[1], obs[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: one expected entry per clock, sampled on the falling edge.
    always @(negedge clk) begin
        if (q_exp.size() != 0) begin
            exp_t e;
            e = q_exp.pop_front();
            check_vec(e.tag, {sif.sel, sif.sel_valid, sif.busy, sif.frame_done}, e.exp);
        end
    end

    // Drive inputs for the next rising edge and queue the outputs expected
    // after it; returns just after the monitor has consumed that entry.
    task automatic drive(input string tag, input logic rn, input logic st,
                         input logic ab, input logic co, input logic [15:0] mk,
                         input logic [3:0] e_sel, input logic e_v,
                         input logic e_b, input logic e_d);
        exp_t e;
        rst_n     = rn;
        sif.start = st;
        sif.abort = ab;
        sif.cont  = co;
        sif.mask  = mk;
        e.tag = tag;
        e.exp = {e_sel, e_v, e_b, e_d};
        q_exp.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sif.start = 1'b1;
        sif.abort = 1'b0;
        sif.cont  = 1'b0;
        sif.mask  = 16'hFFFF;
        @(negedge clk);
        #1;

        // Reset held with start asserted and a full mask.
        for (int k = 0; k < 2; k++)
            drive("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);
        drive("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);

        // Full frame: 16 slots x 4 cycles, then done with valid/busy low.
        for (int k = 0; k < 64; k++)
            drive("full", 1'b1, (k == 0), 1'b0, 1'b0, 16'hFFFF, 4'(k / 4), 1'b1, 1'b1, 1'b0);
        drive("full_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b1);
        drive("full_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-frame while sel=7.
        for (int k = 0; k <= 28; k++)
            drive("mid_run", 1'b1, (k == 0), 1'b0, 1'b0, 16'hFFFF, 4'(k / 4), 1'b1, 1'b1, 1'b0);
        drive("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);
        drive("mid_post", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);

        // Sparse mask 0,5,10,15; live mask changes after the latch.
        for (int k = 0; k < 16; k++)
            drive("sparse", 1'b1, (k == 0), 1'b0, 1'b0, (k == 0) ? 16'h8421 : 16'h0002,
                  4'((k / 4) * 5), 1'b1, 1'b1, 1'b0);
        drive("sparse_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 4'd0, 1'b0, 1'b0, 1'b1);
        drive("sparse_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 4'd0, 1'b0, 1'b0, 1'b0);

        // Empty mask: immediate done pulse, never busy.
        drive("empty_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
        drive("empty_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Abort at sel=3 after an ignored start; no done pulse.
        for (int k = 0; k <= 12; k++)
            drive("abort_run", 1'b1, (k == 0), 1'b0, 1'b0, 16'hFFFF, 4'(k / 4), 1'b1, 1'b1, 1'b0);
        drive("abort_ign_start", 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4'd3, 1'b1, 1'b1, 1'b0);
        drive("abort", 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);
        drive("abort_post", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);
        drive("abort_with_start", 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);
        drive("abort_with_start_post", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b0);

        // Continuous mode on slots 0,1; cont dropped during the fourth frame.
        for (int k = 0; k < 32; k++)
            drive("cont", 1'b1, (k == 0), 1'b0, (k <= 24), 16'h0003,
                  4'((k / 4) % 2), 1'b1, 1'b1, ((k > 0) && (k % 8 == 0)));
        drive("cont_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 4'd0, 1'b0, 1'b0, 1'b1);
        drive("cont_idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
